// File: rtl/bcd_seg_scan.sv
// Multiplexed 7-segment driver: scans NDIG snapshotted BCD digits onto one segment bus.
// Define BCD_SEG_DP_EN to add per-digit decimal points (dp_in / seg_dp).
module bcd_seg_scan #(
   parameter int NDIG        = 4,
   parameter int SCAN_DIV    = 1000,
   parameter bit SEG_ACT_LOW = 1'b1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                en,
   input  logic                blank_en,
   input  logic [4*NDIG-1:0]   bcd_in,
`ifdef BCD_SEG_DP_EN
   input  logic [NDIG-1:0]     dp_in,
   output logic                seg_dp,
`endif
   output logic [6:0]          seg_out,
   output logic [NDIG-1:0]     dig_sel
);

   localparam int CW = $clog2(SCAN_DIV);
   localparam int IW = $clog2(NDIG);
   localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(NDIG - 1);
   localparam logic [6:0]    SEG_OFF  = SEG_ACT_LOW ? 7'h7F : 7'h00;

   if (SCAN_DIV < 2 || NDIG < 2 || NDIG > 8) begin : g_bad_param
      $error("bcd_seg_scan: SCAN_DIV must be >= 2 and NDIG in 2..8");
   end

   logic [CW-1:0]      cnt;
   logic [IW-1:0]      idx;
   logic [4*NDIG-1:0]  bcd_snap;
   logic [NDIG-1:0]    dp_snap;
   logic               load_pending;
   logic               cnt_last;
   logic               snap_load;
   logic [3:0]         snap_dig [NDIG];
   logic [NDIG-1:0]    lead_zero;
   logic [NDIG-1:0]    dig_sel_d;
   logic [6:0]         seg_d;

   assign cnt_last  = (cnt == CNT_LAST);
   assign snap_load = load_pending | (cnt_last & (idx == IDX_LAST));

   function automatic logic [6:0] decode(input logic [3:0] d);
      case (d)
         4'd0:    decode = 7'h3F;
         4'd1:    decode = 7'h06;
         4'd2:    decode = 7'h5B;
         4'd3:    decode = 7'h4F;
         4'd4:    decode = 7'h66;
         4'd5:    decode = 7'h6D;
         4'd6:    decode = 7'h7D;
         4'd7:    decode = 7'h07;
         4'd8:    decode = 7'h7F;
         4'd9:    decode = 7'h6F;
         default: decode = 7'h40;
      endcase
   endfunction

   // Prescaler and digit index; keep running regardless of en.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
         idx <= '0;
      end else if (cnt_last) begin
         // NOTE: state registers use <= so every flop samples pre-edge values.
         cnt <= '0;
         idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   // Snapshot is taken only at scan boundaries so a scan never mixes two values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         // NOTE: a small register file, not a RAM, so it is cleared to keep the first scan X-free.
         bcd_snap     <= '0;
         load_pending <= 1'b1;
      end else if (snap_load) begin
         bcd_snap     <= bcd_in;
         load_pending <= 1'b0;
      end
   end

`ifdef BCD_SEG_DP_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)         dp_snap <= '0;
      else if (snap_load) dp_snap <= dp_in;
   end
`else
   assign dp_snap = '0;
`endif

   always_comb begin
      for (int k = 0; k < NDIG; k++) snap_dig[k] = bcd_snap[4*k +: 4];
   end

   // lead_zero[k]: digits NDIG-1..k are zero with no decimal point among them.
   always_comb begin
      logic run;
      run       = 1'b1;
      lead_zero = '0;
      for (int k = NDIG - 1; k >= 0; k--) begin
         run          = run & (snap_dig[k] == 4'd0) & ~dp_snap[k];
         lead_zero[k] = run;
      end
   end

   always_comb begin
      // NOTE: defaults first so no path through this block can infer a latch.
      dig_sel_d = '0;
      seg_d     = SEG_OFF;
      if (en && cnt != '0) begin
         dig_sel_d[idx] = 1'b1;
         if (!(blank_en && idx != '0 && lead_zero[idx]))
            seg_d = SEG_ACT_LOW ? ~decode(snap_dig[idx]) : decode(snap_dig[idx]);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dig_sel <= '0;
         seg_out <= SEG_OFF;
      end else begin
         dig_sel <= dig_sel_d;
         seg_out <= seg_d;
      end
   end

`ifdef BCD_SEG_DP_EN
   logic dp_lit;
   assign dp_lit = en && (cnt != '0) && dp_snap[idx];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) seg_dp <= SEG_ACT_LOW;
      else        seg_dp <= SEG_ACT_LOW ? ~dp_lit : dp_lit;
   end
`endif

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Scoreboard bench for bcd_seg_scan (NDIG=4, SCAN_DIV=4, active-low segments).
module tb_bcd_seg_scan;

   localparam int NDIG        = 4;
   localparam int SCAN_DIV    = 4;
   localparam bit SEG_ACT_LOW = 1'b1;

   logic        clk;
   logic        reset;
   logic        en;
   logic        blank_en;
   logic [15:0] bcd_in;
   logic [6:0]  seg_out;
   logic [3:0]  dig_sel;
`ifdef BCD_SEG_DP_EN
   logic [3:0]  dp_in;
   logic        seg_dp;
`endif

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [3:0] ds;
      logic [6:0] seg;
      string      tag;
   } exp_t;

   exp_t sb[$];
   event sample_now;

   // Active-low patterns, digit 0 in the lowest slot.
   localparam logic [3:0][6:0] S1234 = {7'h79, 7'h24, 7'h30, 7'h19};
   localparam logic [3:0][6:0] S5678 = {7'h12, 7'h02, 7'h78, 7'h00};
   localparam logic [3:0][6:0] S0050 = {7'h7F, 7'h7F, 7'h12, 7'h40};
   localparam logic [3:0][6:0] S0000 = {7'h7F, 7'h7F, 7'h7F, 7'h40};
   localparam logic [3:0][6:0] S00A0 = {7'h7F, 7'h7F, 7'h3F, 7'h40};
   localparam logic [3:0][6:0] S9876 = {7'h10, 7'h00, 7'h78, 7'h02};

   bcd_seg_scan #(
      .NDIG        (NDIG),
      .SCAN_DIV    (SCAN_DIV),
      .SEG_ACT_LOW (SEG_ACT_LOW)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .en       (en),
      .blank_en (blank_en),
      .bcd_in   (bcd_in),
`ifdef BCD_SEG_DP_EN
      .dp_in    (dp_in),
      .seg_dp   (seg_dp),
`endif
      .seg_out  (seg_out),
      .dig_sel  (dig_sel)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic expect_out(input logic [3:0] ds, input logic [6:0] seg, input string tag);
      exp_t e;
      e.ds  = ds;
      e.seg = seg;
      e.tag = tag;
      sb.push_back(e);
   endtask

   task automatic step(input logic [3:0] ds, input logic [6:0] seg, input string tag);
      @(posedge clk);
      expect_out(ds, seg, tag);
   endtask

   // One scan = 4 slots of 4 clocks: guard then 3 active clocks per digit.
   task automatic scan(input string name, input logic [3:0][6:0] s, input int len,
                       input int act_pos, input logic [15:0] new_bcd, input logic new_blank,
                       input logic [15:0] dark_mask, input int en_off_pos, input int en_on_pos);
      for (int p = 0; p < len; p++) begin
         int    slot;
         string tag;
         slot = p / 4;
         tag  = $sformatf("%s pos%0d", name, p);
         if ((p % 4) == 0 || dark_mask[p])
            step(4'b0000, 7'h7F, tag);
         else
            step(4'(1 << slot), s[slot], tag);
         if (p == act_pos)    begin #1; bcd_in = new_bcd; blank_en = new_blank; end
         if (p == en_off_pos) begin #1; en = 1'b0; end
         if (p == en_on_pos)  begin #1; en = 1'b1; end
      end
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clk or sample_now);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check($sformatf("%s dig_sel", e.tag), 32'(dig_sel), 32'(e.ds));
            check($sformatf("%s seg_out", e.tag), 32'(seg_out), 32'(e.seg));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      reset    = 1'b0;
      en       = 1'b1;
      blank_en = 1'b0;
      bcd_in   = 16'h1234;
`ifdef BCD_SEG_DP_EN
      dp_in    = '0;
`endif
      repeat (3) step(4'b0000, 7'h7F, "reset_hold");
      #2 reset = 1'b1;

      scan("A_1234",  S1234, 16, -1, 16'h0000, 1'b0, 16'h0000, -1, -1);
      scan("B_1234",  S1234, 16, -1, 16'h0000, 1'b0, 16'h0000, -1, -1);
      scan("C_tear",  S1234, 16,  5, 16'h5678, 1'b0, 16'h0000, -1, -1);
      scan("D_5678",  S5678, 16,  5, 16'h0050, 1'b1, 16'h0000, -1, -1);
      scan("E_0050",  S0050, 16,  5, 16'h0000, 1'b1, 16'h0000, -1, -1);
      scan("F_0000",  S0000, 16,  5, 16'h00A0, 1'b1, 16'h0000, -1, -1);
      scan("G_00A0",  S00A0, 16,  5, 16'h1234, 1'b1, 16'h0000, -1, -1);
      scan("H_en_off", S1234, 16, -1, 16'h0000, 1'b1, 16'h3F00,  7, 13);
      scan("I_resume", S1234,  7, -1, 16'h0000, 1'b1, 16'h0000, -1, -1);

      // Reset while digit 1 is lit: outputs must go dark before any clock edge.
      @(negedge clk);
      #2;
      reset  = 1'b0;
      bcd_in = 16'h9876;
      #1;
      expect_out(4'b0000, 7'h7F, "async_reset");
      -> sample_now;
      repeat (2) step(4'b0000, 7'h7F, "reset_mid");
      #2 reset = 1'b1;

      scan("J_fresh", S9876, 16, -1, 16'h0000, 1'b1, 16'h0000, -1, -1);

      @(negedge clk);
      #1;
      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bcd_seg_scan.md
Name: bcd_seg_scan

Overview:
- Multiplexed 7-segment display driver sitting directly downstream of the cascaded single-digit BCD counters.
- Takes NDIG packed BCD digits and drives one common segment bus plus one-hot digit selects, time-sharing the digits.
- Provides glitch-free digit switching, optional leading-zero blanking, and an invalid-code indication.

Parameters:
- NDIG, 4, number of BCD digits scanned (2..8).
- SCAN_DIV, 1000, clk cycles per digit slot; must be >= 2.
- SEG_ACT_LOW, 1, 1 = segment outputs active-low (common anode); 0 = active-high.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  display enable; 0 = all digits dark.
- blank_en  in  1  leading-zero blanking enable.
- bcd_in  in  4*NDIG  packed BCD; digit k = bcd_in[4k+3:4k], digit 0 least significant.
- seg_out  out  7  segments {g,f,e,d,c,b,a}, bit0 = a, polarity per SEG_ACT_LOW.
- dig_sel  out  NDIG  one-hot digit select, active-high; bit k = digit k.

Behaviour:
- Reset is asynchronous and active-low (clock clk).
- Reset values: cnt=0, idx=0, snapshot=0, load_pending=1, dig_sel=0, seg_out=all segments off (7'h7F if SEG_ACT_LOW, else 7'h00).
- Prescaler cnt counts 0..SCAN_DIV-1.
  - At cnt==SCAN_DIV-1: cnt->0 and idx advances, wrapping NDIG-1 -> 0.
- Snapshot register captures bcd_in in two cases:
  - on the first clock with load_pending=1, which then clears load_pending;
  - on every wrap, i.e. cnt==SCAN_DIV-1 with idx==NDIG-1.
  - Between captures, bcd_in changes are not displayed (no tearing within a scan).
- Outputs are registered: each clock they are computed from the current cnt/idx/snapshot, so they show on the next edge (1-cycle latency).
- Guard slot: dig_sel=0 and seg_out=off whenever cnt==0, giving one dark clock per digit change (anti-ghosting). Otherwise dig_sel has only bit idx set.
- Decode (active-high form, bit6..0 = g..a):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Codes A-F show a dash (40).
  - With SEG_ACT_LOW=1 the value is inverted.
- Leading-zero blanking (blank_en=1):
  - Digit k is blanked (segments off, dig_sel still asserted) when digits NDIG-1..k of the snapshot are all 0.
  - Digit 0 is never blanked.
  - An invalid code counts as non-zero.
- en=0: dig_sel=0 and seg_out=off; cnt, idx and the snapshot keep running. When en returns to 1, the display resumes at the current idx on the next edge.
- Reset mid-scan: outputs go dark immediately (asynchronously); after release the scan restarts at digit 0 with a fresh snapshot.
- blank_en and en are used combinationally into the output registers; they are not snapshotted.

Optional Feature:
- Macro: BCD_SEG_DP_EN.
- With the macro defined:
  - extra input dp_in[NDIG-1:0] and output seg_dp (same polarity as seg_out);
  - dp_in is captured into the snapshot together with bcd_in;
  - seg_dp is lit for digit idx when its dp bit is set, and is dark in guard slots, when en=0, and in reset;
  - a digit with dp set is never blanked and ends leading-zero blanking for all less-significant digits.
- Without the macro: no dp_in or seg_dp ports, and blanking depends on digit values only.

Test Plan:
1. Bench configuration for all scenarios: NDIG=4, SCAN_DIV=4, SEG_ACT_LOW=1. Assert reset low mid-scan -> dig_sel=0000 and seg_out=7F immediately; after release the first non-guard slot is dig_sel=0001.
2. bcd_in=16'h1234, en=1, blank_en=0 -> repeating 16-cycle pattern per digit: 1 guard cycle (0000/7F), then 3 cycles active:
   - 0001 with seg 19 ('4');
   - 0010 with seg 30 ('3');
   - 0100 with seg 24 ('2');
   - 1000 with seg 79 ('1').
3. bcd_in=16'h0050, blank_en=1 -> digits 3 and 2 show seg 7F with dig_sel asserted; digit 1 shows 12 ('5'); digit 0 shows 40 ('0'). Then bcd_in=16'h0000 -> only digit 0 lit (40).
4. bcd_in=16'h00A0, blank_en=1 -> digit 1 shows 3F (dash); digit 0 shows 40 ('0'); digits 3 and 2 blanked.
5. Change bcd_in from 1234 to 5678 while idx=1 -> digits 1..3 still show 3/2/1; '8' first appears in the digit 0 slot after the wrap.
6. Drop en to 0 for 6 cycles starting at idx=2 -> dig_sel=0000 and seg_out=7F during that time. After en returns to 1, the next display is idx=3, consistent with the prescaler having kept running.
